text_console_ctrl: RTL and testbench
====================================

Name: text_console_ctrl

Overview:
- Write-side sequencer for the 70x30 VGA character memory.
- Accepts ASCII bytes from the keyboard path over a valid/ready handshake and owns the cursor.
- Turns each byte into character-memory writes and handles newline, backspace, auto-wrap, clear-screen and circular scroll.
- Exports top_row so the VGA read side rotates the displayed rows.

Parameters:
COLS, 70, visible columns per row
ROWS, 30, visible rows
KEY_ENTER, 8'h0A, newline code
KEY_BS, 8'h08, backspace code
KEY_CLR, 8'h0C, clear-screen code

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
key_in  in  8  ASCII byte from keyboard path
key_valid  in  1  key_in valid
key_ready  out  1  controller can accept a byte this cycle
mem_we  out  1  character-memory write strobe
mem_addr  out  12  write address {row[4:0], col[6:0]}, physical row
mem_wdata  out  8  write data
top_row  out  5  physical row shown as screen line 0
cur_x  out  7  cursor column, 0..COLS-1
cur_y  out  5  cursor physical row, 0..ROWS-1
busy  out  1  high in CLEAR_ALL or CLR_LINE

Behaviour:
- All outputs are registered.
- Reset values:
  - state is CLEAR_ALL.
  - mem_we, mem_addr, mem_wdata, top_row, cur_x, cur_y are 0.
  - Internal lines_used counter (5 bits) is 0.
  - key_ready is 0; busy is 1.
- Handshake:
  - A byte is accepted on a rising edge with key_valid & key_ready.
  - key_ready is 1 only in IDLE.
  - A producer holding key_valid while key_ready is 0 is stalled; it is not dropped.
- IDLE:
  - On accept, the action is decided by key_in:
  - 8'h20..8'h7E: go to WRITE. mem_we=1, addr={cur_y,cur_x}, data=key_in on the next cycle, then advance the cursor.
  - KEY_ENTER: newline, no write.
  - KEY_BS:
    - If cur_x>0: cur_x-1, then WRITE 8'h20 at the new position.
    - If cur_x==0: no-op; the cursor never moves to the previous line.
  - KEY_CLR: go to CLEAR_ALL. cur_x, cur_y, top_row and lines_used are set to 0.
  - Any other code: consumed and ignored. Stay in IDLE, key_ready stays 1.
- WRITE (1 cycle):
  - mem_we pulses for exactly one cycle; key_ready=0.
  - Cursor advance after a printable write:
    - If cur_x==COLS-1, apply newline.
    - Otherwise cur_x+1.
  - Next state is IDLE, or CLR_LINE if the newline scrolls.
- Newline:
  - cur_x<=0; cur_y<=(cur_y==ROWS-1)?0:cur_y+1.
  - If lines_used<ROWS-1: lines_used+1, return to IDLE.
  - Otherwise (screen full) scroll:
    - top_row<=(top_row==ROWS-1)?0:top_row+1.
    - Go to CLR_LINE for the new cur_y.
- CLR_LINE:
  - Writes 8'h00 to cols 0..COLS-1 of row cur_y, one per cycle, in ascending order.
  - Takes exactly COLS cycles with mem_we=1, then returns to IDLE.
- CLEAR_ALL:
  - Writes 8'h00 to every visible cell in row-major order: row 0 col 0 .. row ROWS-1 col COLS-1.
  - Takes ROWS*COLS = 2100 cycles, then returns to IDLE.
  - Addresses with col>=COLS are never written.
- mem_we is 0 in IDLE.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- Latency: first write strobe is 1 cycle after the accept edge; peak throughput is 1 byte per 2 cycles.
- Reset asserted mid-clear, mid-scroll or mid-write aborts immediately to reset values. The full clear restarts after release.
- All row/col arithmetic wraps explicitly against ROWS/COLS, never on natural bit width.

Test Plan:
- Release reset, hold key_valid=0 → exactly 2100 mem_we pulses, covering addr 12'h000..{5'd29,7'd69} with data 0, skipping col>=70. Then key_ready=1, busy=0.
- After clear, send 'A' (8'h41) then 'B' → writes {0,0}=41 and {0,1}=42, one cycle after each accept. Final cur_x=2, cur_y=0.
- Send 70 × 'x' → last write at col 69. Then cur_x=0, cur_y=1, no CLR_LINE, top_row=0.
- Send 'Q', KEY_BS, KEY_BS → space (8'h20) written at {0,0}; cur_x=0; second BS produces no write.
- Send 29 × KEY_ENTER, then 1 more → cur_y=0, top_row=1, 70 zero writes to row 0 cols 0..69. key_valid held during these cycles stalls until IDLE.
- Assert reset during CLR_LINE → outputs return to reset values the same cycle; full 2100-cycle clear follows release.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Write-side sequencer for the character memory: turns accepted ASCII bytes into
// cell writes and owns the cursor, newline/backspace/auto-wrap, clear-screen and scroll.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | ready for a byte, no memory write
// WRITE       | single-cycle write of a printable byte or a backspace blank
// CLR_LINE    | blanking the freshly scrolled-in row, one column per cycle
// CLEAR_ALL   | blanking every visible cell, row-major
module text_console_ctrl #(
  parameter int         COLS      = 70,
  parameter int         ROWS      = 30,
  parameter logic [7:0] KEY_ENTER = 8'h0A,
  parameter logic [7:0] KEY_BS    = 8'h08,
  parameter logic [7:0] KEY_CLR   = 8'h0C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [4:0]  top_row,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLR_LINE,
    S_CLEAR_ALL
  } state_t;

  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [11:0] CELLS    = 12'(ROWS * COLS);

  state_t      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [4:0]  top_row_q, top_row_d;
  logic [4:0]  lines_used_q, lines_used_d;
  logic [11:0] wr_left_q, wr_left_d;
  logic        adv_q, adv_d;
  logic        mem_we_q, mem_we_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        key_ready_q, key_ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        newline;
  logic [6:0]  clr_col;
  logic [4:0]  clr_row;
  logic [11:0] next_cell;

  assign accept = key_valid & key_ready_q;

  // wr_left counts the writes still owed after the one currently on the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR_ALL;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      top_row_q    <= '0;
      lines_used_q <= '0;
      wr_left_q    <= CELLS;
      adv_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      key_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      top_row_q    <= top_row_d;
      lines_used_q <= lines_used_d;
      wr_left_q    <= wr_left_d;
      adv_q        <= adv_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      key_ready_q  <= key_ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    top_row_d    = top_row_q;
    lines_used_d = lines_used_q;
    wr_left_d    = wr_left_q;
    adv_d        = adv_q;
    newline      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (key_in >= 8'h20 && key_in <= 8'h7E) begin
            state_d = S_WRITE;
            adv_d   = 1'b1;
          end else if (key_in == KEY_ENTER) begin
            newline = 1'b1;
          end else if (key_in == KEY_BS) begin
            if (cur_x_q != 7'd0) begin
              cur_x_d = cur_x_q - 7'd1;
              state_d = S_WRITE;
              adv_d   = 1'b0;
            end
          end else if (key_in == KEY_CLR) begin
            state_d      = S_CLEAR_ALL;
            cur_x_d      = '0;
            cur_y_d      = '0;
            top_row_d    = '0;
            lines_used_d = '0;
            wr_left_d    = CELLS - 12'd1;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (adv_q) begin
          if (cur_x_q == LAST_COL) newline = 1'b1;
          else                     cur_x_d = cur_x_q + 7'd1;
        end
      end
      S_CLR_LINE, S_CLEAR_ALL: begin
        if (wr_left_q == 12'd0) state_d = S_IDLE;
        else                    wr_left_d = wr_left_q - 12'd1;
      end
      default: state_d = S_CLEAR_ALL;
    endcase

    // once the screen is full every newline recycles the oldest row
    if (newline) begin
      cur_x_d = '0;
      cur_y_d = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;
      if (lines_used_q < LAST_ROW) begin
        lines_used_d = lines_used_q + 5'd1;
      end else begin
        top_row_d = (top_row_q == LAST_ROW) ? 5'd0 : top_row_q + 5'd1;
        state_d   = S_CLR_LINE;
        wr_left_d = 12'(COLS - 1);
      end
    end
  end

  assign clr_col   = mem_addr_q[6:0];
  assign clr_row   = mem_addr_q[11:7];
  assign next_cell = (clr_col == LAST_COL) ? {clr_row + 5'd1, 7'd0}
                                           : {clr_row, clr_col + 7'd1};

  always_comb begin
    mem_we_d    = (state_d != S_IDLE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    key_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_CLR_LINE) || (state_d == S_CLEAR_ALL);

    case (state_d)
      S_WRITE: begin
        mem_addr_d  = {cur_y_d, cur_x_d};
        mem_wdata_d = adv_d ? key_in : 8'h20;
      end
      S_CLR_LINE: begin
        mem_addr_d  = (state_q == S_CLR_LINE) ? {clr_row, clr_col + 7'd1}
                                              : {cur_y_d, 7'd0};
        mem_wdata_d = 8'h00;
      end
      S_CLEAR_ALL: begin
        // the cycle right after reset has no write on the bus yet, so start at cell 0
        mem_addr_d  = (state_q == S_CLEAR_ALL && mem_we_q) ? next_cell : 12'd0;
        mem_wdata_d = 8'h00;
      end
      default: ;
    endcase
  end

  assign key_ready = key_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign top_row   = top_row_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: a screen-level model predicts the write stream and
// cursor, checked every cycle, plus directed scenarios with literal expectations.
module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  key_in = 8'h00;
  logic        key_valid = 1'b0;
  logic        key_ready, mem_we, busy;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [4:0]  top_row, cur_y;
  logic [6:0]  cur_x;

  always #5 clk = ~clk;

  text_console_ctrl dut (
    .clk(clk), .reset(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .top_row(top_row), .cur_x(cur_x),
    .cur_y(cur_y), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  int mx, my, mtop, mlines;
  int we_count = 0;
  logic [11:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int snap;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void push_w(input int row, input int col, input int data);
    exp_addr_q.push_back(12'(row * 128 + col));
    exp_data_q.push_back(8'(data));
  endfunction

  function automatic void push_clear_all();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 70; c++) push_w(r, c, 0);
  endfunction

  function automatic void model_reset();
    exp_addr_q.delete();
    exp_data_q.delete();
    mx = 0; my = 0; mtop = 0; mlines = 0;
    push_clear_all();
  endfunction

  function automatic void model_newline();
    mx = 0;
    my = (my + 1) % 30;
    if (mlines < 29) mlines++;
    else begin
      mtop = (mtop + 1) % 30;
      for (int c = 0; c < 70; c++) push_w(my, c, 0);
    end
  endfunction

  function automatic void model_accept(input int k);
    if (k >= 32 && k <= 126) begin
      push_w(my, mx, k);
      if (mx == 69) model_newline();
      else mx++;
    end else if (k == 10) begin
      model_newline();
    end else if (k == 8) begin
      if (mx > 0) begin
        mx--;
        push_w(my, mx, 32);
      end
    end else if (k == 12) begin
      mx = 0; my = 0; mtop = 0; mlines = 0;
      push_clear_all();
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_vs_pending", key_ready, int'(exp_addr_q.size() == 0));
      if (key_ready) begin
        chk("idle_busy", busy, 0);
        chk("idle_we", mem_we, 0);
        chk("cur_x", cur_x, mx);
        chk("cur_y", cur_y, my);
        chk("top_row", top_row, mtop);
      end
      if (mem_we) begin
        we_count++;
        last_addr = mem_addr;
        last_data = mem_wdata;
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wdata);
        end else begin
          chk("wr_addr", mem_addr, exp_addr_q[0]);
          chk("wr_data", mem_wdata, exp_data_q[0]);
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (!key_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, key_ready, 1);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    wait_ready(3000, "idle_timeout");
  endtask

  task automatic send(input logic [7:0] k);
    key_in = k;
    key_valid = 1'b1;
    wait_ready(3000, "send_timeout");
    @(posedge clk);
    model_accept(int'(k));
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] k, input logic [11:0] ea, input logic [7:0] ed);
    send(k);
    chk("lat_we", mem_we, 1);
    chk("lat_addr", mem_addr, ea);
    chk("lat_data", mem_wdata, ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_ready", key_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_wdata, 0);
    chk("rst_top", top_row, 0);
    chk("rst_x", cur_x, 0);
    chk("rst_y", cur_y, 0);
    we_count = 0;
    rst = 1'b0;
    wait_idle();
    chk("init_clear_count", we_count, 2100);
    chk("init_clear_last", last_addr, 12'hEC5);
    chk("init_busy", busy, 0);

    send_chk(8'h41, 12'h000, 8'h41);
    send_chk(8'h42, 12'h001, 8'h42);
    wait_idle();
    chk("ab_x", cur_x, 2);
    chk("ab_y", cur_y, 0);

    send(8'h0A);
    wait_idle();
    snap = we_count;
    for (int i = 0; i < 70; i++) send(8'h78);
    wait_idle();
    chk("wrap_last", last_addr, 12'h0C5);
    chk("wrap_count", we_count - snap, 70);
    chk("wrap_x", cur_x, 0);
    chk("wrap_y", cur_y, 2);
    chk("wrap_top", top_row, 0);

    send(8'h51);
    send(8'h08);
    wait_idle();
    chk("bs_addr", last_addr, 12'h100);
    chk("bs_data", last_data, 8'h20);
    snap = we_count;
    send(8'h08);
    wait_idle();
    chk("bs0_nowrite", we_count - snap, 0);
    chk("bs0_x", cur_x, 0);

    snap = we_count;
    send(8'h01);
    send(8'h7F);
    send(8'hC3);
    wait_idle();
    chk("ignored_nowrite", we_count - snap, 0);

    snap = we_count;
    send(8'h0C);
    wait_idle();
    chk("clr_count", we_count - snap, 2100);
    chk("clr_y", cur_y, 0);

    for (int i = 0; i < 29; i++) send(8'h0A);
    wait_idle();
    chk("fill_y", cur_y, 29);
    chk("fill_top", top_row, 0);
    snap = we_count;
    send(8'h0A);
    send(8'h5A);
    wait_idle();
    chk("scroll_y", cur_y, 0);
    chk("scroll_top", top_row, 1);
    chk("scroll_count", we_count - snap, 71);
    chk("stall_addr", last_addr, 12'h000);
    chk("stall_data", last_data, 8'h5A);

    for (int i = 0; i < 29; i++) send(8'h0A);
    wait_idle();
    chk("topwrap_top", top_row, 0);
    chk("topwrap_y", cur_y, 29);

    snap = we_count;
    for (int i = 0; i < 70; i++) send(8'h78);
    wait_idle();
    chk("autoscroll_count", we_count - snap, 140);
    chk("autoscroll_last", last_addr, 12'h045);
    chk("autoscroll_top", top_row, 1);
    chk("autoscroll_y", cur_y, 0);

    send(8'h0A);
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_ready", key_ready, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_top", top_row, 0);
    chk("mid_rst_y", cur_y, 0);
    model_reset();
    we_count = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    chk("reclear_count", we_count, 2100);
    send_chk(8'h41, 12'h000, 8'h41);
    wait_idle();
    chk("drained", exp_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
